// File: rtl/fixed_matmul_streamer_pkg.sv
// Shared types for the matmul weight streamer: FSM state encoding and pointer-width helper.
// Optional feature macro used by the top: MATMUL_STREAMER_FLUSH_EN.
package fixed_matmul_streamer_pkg;

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Counter width for n states; a 1-entry counter still needs one bit.
  function automatic int ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_tile_regfile.sv
// Tile buffer: DEPTH tile-wide registers, one synchronous write port, one async read port.
// Contents are deliberately not reset.
module matmul_tile_regfile #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 24,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fixed_matmul_weight_streamer.sv
// Captures one weight matrix (IN_DEPTH tiles) then replays it REPEAT times on a valid/ready stream.
// Define MATMUL_STREAMER_FLUSH_EN to add the flush port that abandons the current matrix.
module fixed_matmul_weight_streamer
  import fixed_matmul_streamer_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int IN_SIZE         = 1,
  parameter int IN2_PARALLELISM = 3,
  parameter int IN_DEPTH        = 3,
  parameter int REPEAT          = 4
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [IN_SIZE*IN2_PARALLELISM-1:0][DATA_WIDTH-1:0] data_in,
  input  logic                                               data_in_valid,
  output logic                                               data_in_ready,
  output logic [IN_SIZE*IN2_PARALLELISM-1:0][DATA_WIDTH-1:0] data_out,
  output logic                                               data_out_valid,
  input  logic                                               data_out_ready
`ifdef MATMUL_STREAMER_FLUSH_EN
  ,
  input  logic                                               flush
`endif
);

  localparam int NE = IN_SIZE * IN2_PARALLELISM;
  localparam int TW = NE * DATA_WIDTH;
  localparam int PW = ptr_w(IN_DEPTH);
  localparam int CW = ptr_w(REPEAT);

  state_e          r_state, w_state_nxt;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_pass_cnt;
  logic            w_flush;
  logic            w_in_hs, w_out_hs;
  logic            w_last_wr, w_last_rd, w_last_pass;
  logic [TW-1:0]   w_rd_data;

`ifdef MATMUL_STREAMER_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_in_hs     = data_in_valid  & data_in_ready;
  assign w_out_hs    = data_out_valid & data_out_ready;
  assign w_last_wr   = (r_wr_ptr   == PW'(IN_DEPTH - 1));
  assign w_last_rd   = (r_rd_ptr   == PW'(IN_DEPTH - 1));
  assign w_last_pass = (r_pass_cnt == CW'(REPEAT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_flush) begin
      w_state_nxt = LOAD;
    end else begin
      case (r_state)
        LOAD:    if (w_in_hs && w_last_wr) w_state_nxt = STREAM;
        STREAM:  if (w_out_hs && w_last_rd && w_last_pass) w_state_nxt = LOAD;
        default: w_state_nxt = LOAD;
      endcase
    end
  end

  // flush gates both handshakes so a colliding tile or pass is discarded.
  always_comb begin
    data_in_ready  = 1'b0;
    data_out_valid = 1'b0;
    case (r_state)
      LOAD:    data_in_ready  = ~w_flush;
      STREAM:  data_out_valid = ~w_flush;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pass_cnt <= '0;
    end else begin
      if (w_in_hs) r_wr_ptr <= w_last_wr ? '0 : r_wr_ptr + PW'(1);
      if (w_out_hs) begin
        r_rd_ptr <= w_last_rd ? '0 : r_rd_ptr + PW'(1);
        if (w_last_rd) r_pass_cnt <= w_last_pass ? '0 : r_pass_cnt + CW'(1);
      end
    end
  end

  matmul_tile_regfile #(
    .DEPTH (IN_DEPTH),
    .WIDTH (TW),
    .AW    (PW)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_in_hs),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (data_in),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign data_out = w_rd_data;

endmodule

// File: tb/tb_fixed_matmul_weight_streamer.sv
// Scoreboard bench for the weight streamer: monitor checks handshake-level behaviour against a
// queue of expected replayed tiles built from the tiles the bench itself loaded.
module tb_fixed_matmul_weight_streamer;

  localparam int DW  = 8;
  localparam int ISZ = 1;
  localparam int PAR = 3;
  localparam int DEP = 3;
  localparam int REP = 2;
  localparam int NE  = ISZ * PAR;
  localparam int TW  = NE * DW;

  typedef logic [NE-1:0][DW-1:0] tile_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  tile_t data_in = '0;
  logic  data_in_valid = 1'b0;
  logic  data_in_ready;
  tile_t data_out;
  logic  data_out_valid;
  logic  data_out_ready = 1'b1;
`ifdef MATMUL_STREAMER_FLUSH_EN
  logic  flush = 1'b0;
`endif

  fixed_matmul_weight_streamer #(
    .DATA_WIDTH      (DW),
    .IN_SIZE         (ISZ),
    .IN2_PARALLELISM (PAR),
    .IN_DEPTH        (DEP),
    .REPEAT          (REP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
`ifdef MATMUL_STREAMER_FLUSH_EN
    ,
    .flush          (flush)
`endif
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_out    = 0;
  int    rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random
  tile_t exp_q[$];
  tile_t ld_q[$];
  logic  stall_prev = 1'b0;
  tile_t hold_data;

  task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: idle (accepting) while nothing is pending, otherwise replaying exp_q.
  always @(negedge clk) begin
    logic flushing;
    logic streaming;
    flushing = 1'b0;
`ifdef MATMUL_STREAMER_FLUSH_EN
    flushing = flush;
`endif
    if (rst) begin
      exp_q.delete(); ld_q.delete(); stall_prev = 1'b0;
    end else if (flushing) begin
      check("flush_ready", TW'(data_in_ready), TW'(0));
      check("flush_valid", TW'(data_out_valid), TW'(0));
      exp_q.delete(); ld_q.delete(); stall_prev = 1'b0;
    end else begin
      streaming = (exp_q.size() != 0);
      check("in_ready", TW'(data_in_ready), TW'(!streaming));
      check("out_valid", TW'(data_out_valid), TW'(streaming));
      if (stall_prev) check("hold_data", data_out, hold_data);
      if (streaming) begin
        if (data_out_ready) begin
          check("out_data", data_out, exp_q[0]);
          void'(exp_q.pop_front());
          n_out++;
        end
      end else if (data_in_valid) begin
        ld_q.push_back(data_in);
        if (ld_q.size() == DEP) begin
          for (int r = 0; r < REP; r++)
            for (int i = 0; i < DEP; i++) exp_q.push_back(ld_q[i]);
          ld_q.delete();
        end
      end
      stall_prev = streaming && !data_out_ready;
      hold_data  = data_out;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       data_out_ready = 1'b1;
      1:       data_out_ready = ~data_out_ready;
      default: data_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_tile(input tile_t t, input int gap);
    logic got;
    got = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    data_in = t;
    data_in_valid = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk); got = data_in_ready;
      tick();
    end
    data_in_valid = 1'b0;
    if (!got) check("send_timeout", TW'(0), TW'(1));
  endtask

  task automatic seq_tile(input int base, output tile_t t);
    for (int e = 0; e < NE; e++) t[e] = DW'(base + e);
  endtask

  task automatic load_seq(input int base, input int gap);
    tile_t t;
    for (int i = 0; i < DEP; i++) begin
      seq_tile(base + i * NE, t);
      send_tile(t, gap);
    end
  endtask

  task automatic load_rand(input int maxgap);
    tile_t t;
    for (int i = 0; i < DEP; i++) begin
      for (int e = 0; e < NE; e++) t[e] = DW'($urandom);
      send_tile(t, int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !rst;
      tick();
    end
    if (!done) check("drain_timeout", TW'(0), TW'(1));
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();

    rdy_mode = 0; load_seq(1, 0);  wait_idle();
    rdy_mode = 1; load_seq(1, 0);  wait_idle();
    rdy_mode = 0; load_seq(1, 1);  wait_idle();

    load_rand(0); load_seq(10, 0); wait_idle();

    begin : mid_reset
      int base;
      base = n_out;
      load_rand(0);
      for (int c = 0; c < 100 && n_out < base + 4; c++) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      load_seq(40, 0); wait_idle();
    end

    rdy_mode = 2;
    for (int m = 0; m < 6; m++) load_rand(2);
    wait_idle();

`ifdef MATMUL_STREAMER_FLUSH_EN
    rdy_mode = 0;
    begin : flush_case
      tile_t t;
      seq_tile(90, t); send_tile(t, 0);
      seq_tile(93, t); send_tile(t, 0);
      flush = 1'b1; tick(); flush = 1'b0;
      load_seq(100, 0); wait_idle();
    end
`endif

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
